// File: rtl/byte_packer.sv
// byte_packer
//   Gathers a stream of 8-bit bytes into 32-bit words. Bytes are collected in
//   an assembly register. A finished word (4 bytes), or a flushed partial word
//   with byte enables, is moved into a separate output register. Because the
//   two registers are separate, filling continues while a word waits.
//
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   in_data    byte from source
//   in_valid   in_data valid
//   in_ready   byte accepted when in_valid & in_ready
//   flush      level request: emit current partial word
//   out_data   assembled word
//   out_be     byte enables, bit i = lane [8i+:8]
//   out_valid  out_data/out_be valid, held until out_ready
//   out_ready  consumer takes word when out_valid & out_ready
//   fill_cnt   bytes currently held in assembly register (0..3)
module byte_packer #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  fill_cnt
);

    logic [31:0] asm_q,       asm_d;
    logic [1:0]  fill_q,      fill_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [3:0]  out_be_q,    out_be_d;
    logic        out_valid_q, out_valid_d;

    logic        slot_free;
    logic        accept;
    logic        complete;
    logic        flush_fire;
    logic [1:0]  lane;
    logic [2:0]  n_filled;
    logic [31:0] merged;
    logic [3:0]  merged_be;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (fill_q != 2'd3) || slot_free;
    assign accept    = in_valid && in_ready;
    assign lane      = BIG_ENDIAN ? (2'd3 - fill_q) : fill_q;

    // A 4th byte is only accepted when the output slot is free, so
    // completion never needs its own slot_free term.
    assign complete   = accept && (fill_q == 2'd3);
    assign flush_fire = flush && slot_free && ((fill_q != 2'd0) || accept);

    always_comb begin
        merged = asm_q;
        if (accept) begin
            merged = asm_q | ({24'b0, in_data} << {lane, 3'b000});
        end
    end

    // Enables derive from the number of filled lanes, counting a
    // same-cycle byte; lanes fill from the low or high end by endianness.
    always_comb begin
        n_filled  = {1'b0, fill_q} + {2'b00, accept};
        merged_be = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (BIG_ENDIAN) begin
                merged_be[i] = (3'(3 - i) < n_filled);
            end else begin
                merged_be[i] = (3'(i) < n_filled);
            end
        end
    end

    always_comb begin
        asm_d       = asm_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (complete || flush_fire) begin
            out_data_d  = merged;
            out_be_d    = merged_be;
            out_valid_d = 1'b1;
            asm_d       = '0;
            fill_d      = 2'd0;
        end else if (accept) begin
            asm_d  = merged;
            fill_d = fill_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_q       <= '0;
            fill_q      <= 2'd0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_be    = out_be_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        le_in_ready, be_in_ready;
    logic [31:0] le_data, be_data;
    logic [3:0]  le_be, be_be;
    logic        le_valid, be_valid;
    logic [1:0]  le_fill, be_fill;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Expected {data, be} per endianness, pushed when stimulus is driven.
    logic [35:0] q_le[$];
    logic [35:0] q_be[$];

    always #5 clk = ~clk;

    byte_packer #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(le_in_ready), .flush(flush), .out_data(le_data), .out_be(le_be),
        .out_valid(le_valid), .out_ready(out_ready), .fill_cnt(le_fill)
    );

    byte_packer #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(be_in_ready), .flush(flush), .out_data(be_data), .out_be(be_be),
        .out_valid(be_valid), .out_ready(out_ready), .fill_cnt(be_fill)
    );

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] ld, input logic [3:0] lb,
                            input logic [31:0] bd, input logic [3:0] bb);
        q_le.push_back({lb, ld});
        q_be.push_back({bb, bd});
    endtask

    // Drive one byte and hold it until the handshake edge has passed.
    task automatic send(input logic [7:0] b);
        logic hs;
        logic done;
        done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = le_in_ready;
            @(posedge clk);
            #1;
            if (hs) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 36'd0, 36'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: words are compared on the negedge before the edge
    // that consumes them; inputs only change just after posedge.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [35:0] prev_le = '0, prev_be = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", {35'd0, le_valid}, 36'd1);
                chk("hold_le", {le_be, le_data}, prev_le);
                chk("hold_be", {be_be, be_data}, prev_be);
            end
            if (le_valid && out_ready) begin
                if (q_le.size() == 0) chk("le_unexpected", {le_be, le_data}, 36'd0);
                else chk("le_word", {le_be, le_data}, q_le.pop_front());
            end
            if (be_valid && out_ready) begin
                if (q_be.size() == 0) chk("be_unexpected", {be_be, be_data}, 36'd0);
                else chk("be_word", {be_be, be_data}, q_be.pop_front());
            end
            prev_v  = le_valid;
            prev_r  = out_ready;
            prev_le = {le_be, le_data};
            prev_be = {be_be, be_data};
        end
    end

    initial begin
        #2 resetn = 1'b0;
        #5;
        chk("rst_valid", {35'd0, le_valid}, 36'd0);
        chk("rst_data", {le_be, le_data}, 36'd0);
        chk("rst_fill", {34'd0, le_fill}, 36'd0);
        chk("rst_in_ready", {35'd0, le_in_ready}, 36'd1);
        @(posedge clk);
        #1 resetn = 1'b1;
        cycles(1);

        // 1: full word, out_ready high, latency one cycle after 4th byte
        out_ready = 1'b1;
        push_exp(32'h44332211, 4'hF, 32'h11223344, 4'hF);
        send(8'h11); send(8'h22); send(8'h33);
        chk("t1_fill3", {34'd0, le_fill}, 36'd3);
        send(8'h44);
        chk("t1_latency", {35'd0, le_valid}, 36'd1);
        chk("t1_fill0", {34'd0, le_fill}, 36'd0);
        cycles(2);

        // 2: backpressure, held word, in_ready gating, no bubble
        out_ready = 1'b0;
        push_exp(32'h04030201, 4'hF, 32'h01020304, 4'hF);
        push_exp(32'h08070605, 4'hF, 32'h05060708, 4'hF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06); send(8'h07);
        in_data = 8'h08;
        in_valid = 1'b1;
        chk("t2_in_ready_lo", {35'd0, le_in_ready}, 36'd0);
        cycles(3);
        chk("t2_fill_hold", {34'd0, le_fill}, 36'd3);
        chk("t2_in_ready_be", {35'd0, be_in_ready}, 36'd0);
        out_ready = 1'b1;
        send(8'h08);
        chk("t2_no_bubble", {35'd0, le_valid}, 36'd1);
        cycles(2);
        chk("t2_drained", {35'd0, le_valid}, 36'd0);

        // 3: flush of two bytes
        push_exp(32'h0000BBAA, 4'b0011, 32'hAABB0000, 4'b1100);
        send(8'hAA); send(8'hBB);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        chk("t3_valid", {35'd0, le_valid}, 36'd1);
        chk("t3_fill", {34'd0, le_fill}, 36'd0);
        cycles(2);

        // 4: flush in the same cycle as the third byte
        push_exp(32'h00302010, 4'b0111, 32'h10203000, 4'b1110);
        send(8'h10); send(8'h20);
        flush = 1'b1;
        send(8'h30);
        flush = 1'b0;
        chk("t4_fill", {34'd0, le_fill}, 36'd0);
        cycles(2);

        // 4b: flush with nothing held is a no-op
        flush = 1'b1;
        cycles(2);
        flush = 1'b0;
        chk("t4_noop", {35'd0, le_valid}, 36'd0);

        // 5: asynchronous reset mid-word
        send(8'h55); send(8'h66);
        #2 resetn = 1'b0;
        #1;
        chk("t5_data", {le_be, le_data}, 36'd0);
        chk("t5_valid", {35'd0, le_valid}, 36'd0);
        chk("t5_fill", {34'd0, le_fill}, 36'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        push_exp(32'h04030201, 4'hF, 32'h01020304, 4'hF);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        cycles(2);

        // 6: single-byte flush (lane placement differs per endianness)
        push_exp(32'h00000011, 4'b0001, 32'h11000000, 4'b1000);
        send(8'h11);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(3);

        chk("le_queue_empty", 36'(q_le.size()), 36'd0);
        chk("be_queue_empty", 36'(q_be.size()), 36'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
